ycbcr_stream_gen: RTL and testbench



---
 rtl/ycbcr_stream_gen.sv | 232 +++++++++++++++++++++++
 tb/tb_ycbcr_stream_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr_stream_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ycbcr_stream_gen                                                         |
// | Synthetic OV7670-style YCbCr 4:2:2 transmitter with per-pixel sideband.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ycbcr_stream_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int V_BLANK     = 10,
  parameter int VSYNC_LINES = 3,
  parameter int BOX_X0      = 256,
  parameter int BOX_Y0      = 192,
  parameter int BOX_W       = 128,
  parameter int BOX_H       = 96
) (
  input  logic       PCLK,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] mode,
  output logic       VSYNC,
  output logic       HREF,
  output logic [7:0] D,
  output logic       e_pix,
  output logic [7:0] Y,
  output logic [7:0] Cb,
  output logic [7:0] Cr,
  output logic       frame_done
);

  localparam int C_LINE_LEN = 2 * H_ACTIVE + H_BLANK;
  localparam int C_N_LINES  = V_BLANK + V_ACTIVE;
  localparam int CW         = $clog2(C_LINE_LEN);
  localparam int LW         = $clog2(C_N_LINES);

  // Box edges clipped to the active area so the compares never exceed the counter range
  localparam int C_BX0_I = (BOX_X0 > H_ACTIVE) ? H_ACTIVE : BOX_X0;
  localparam int C_BX1_I = (BOX_X0 + BOX_W > H_ACTIVE) ? H_ACTIVE : BOX_X0 + BOX_W;
  localparam int C_BY0_I = (BOX_Y0 > V_ACTIVE) ? V_ACTIVE : BOX_Y0;
  localparam int C_BY1_I = (BOX_Y0 + BOX_H > V_ACTIVE) ? V_ACTIVE : BOX_Y0 + BOX_H;

  localparam logic [CW-1:0] C_BOX_X0   = CW'(C_BX0_I);
  localparam logic [CW-1:0] C_BOX_X1   = CW'(C_BX1_I);
  localparam logic [LW-1:0] C_BOX_Y0   = LW'(C_BY0_I);
  localparam logic [LW-1:0] C_BOX_Y1   = LW'(C_BY1_I);
  localparam logic [CW-1:0] C_BAR1     = CW'(H_ACTIVE / 4);
  localparam logic [CW-1:0] C_BAR2     = CW'(H_ACTIVE / 2);
  localparam logic [CW-1:0] C_BAR3     = CW'((3 * H_ACTIVE) / 4);
  localparam logic [CW-1:0] C_HREF_END = CW'(2 * H_ACTIVE);
  localparam logic [CW-1:0] C_COL_LAST = CW'(C_LINE_LEN - 1);
  localparam logic [LW-1:0] C_VS_LAST  = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] C_VB_LAST  = LW'(V_BLANK - 1);
  localparam logic [LW-1:0] C_LN_LAST  = LW'(C_N_LINES - 1);
  localparam logic [LW-1:0] C_VB_LINES = LW'(V_BLANK);

  localparam logic [1:0] C_GRAY  = 2'd0;
  localparam logic [1:0] C_GREEN = 2'd1;
  localparam logic [1:0] C_RED   = 2'd2;
  localparam logic [1:0] C_BLUE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_VSYNC  = 2'd1,
    S_VBLANK = 2'd2,
    S_ACTIVE = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [LW-1:0] r_line;
  logic [1:0]    r_mode;

  logic [CW-1:0] w_px;
  logic [CW-1:0] w_px_even;
  logic [LW-1:0] w_ay;
  logic [1:0]    w_id_px;
  logic [1:0]    w_id_pair;
  logic [7:0]    w_y;
  logic [7:0]    w_cb;
  logic [7:0]    w_cr;
  logic [7:0]    w_byte;
  logic          w_href;
  logic          w_strobe;
  logic          w_col_last;
  logic          w_frame_last;

  function automatic logic [1:0] pix_colour(input logic [CW-1:0] px,
                                            input logic [LW-1:0] ay,
                                            input logic [1:0]    m);
    logic [1:0] id;
    id = C_GRAY;
    case (m)
      2'd0: begin
        if (px >= C_BOX_X0 && px < C_BOX_X1 && ay >= C_BOX_Y0 && ay < C_BOX_Y1)
          id = C_GREEN;
      end
      2'd1: begin
        if (px < C_BAR1)      id = C_GREEN;
        else if (px < C_BAR2) id = C_RED;
        else if (px < C_BAR3) id = C_BLUE;
        else                  id = C_GRAY;
      end
      2'd2:    id = C_GRAY;
      default: id = C_GREEN;
    endcase
    return id;
  endfunction

  function automatic logic [7:0] luma(input logic [1:0] id);
    case (id)
      C_GREEN: return 8'h91;
      C_RED:   return 8'h51;
      C_BLUE:  return 8'h29;
      default: return 8'h80;
    endcase
  endfunction

  function automatic logic [7:0] chroma_b(input logic [1:0] id);
    case (id)
      C_GREEN: return 8'h36;
      C_RED:   return 8'h5A;
      C_BLUE:  return 8'hF0;
      default: return 8'h80;
    endcase
  endfunction

  function automatic logic [7:0] chroma_r(input logic [1:0] id);
    case (id)
      C_GREEN: return 8'h22;
      C_RED:   return 8'hF0;
      C_BLUE:  return 8'h6E;
      default: return 8'h80;
    endcase
  endfunction

  // Chroma always comes from the even pixel of the pair, luma from the byte's own pixel
  always_comb begin
    w_px         = r_col >> 1;
    w_px_even    = w_px & ~CW'(1);
    w_ay         = r_line - C_VB_LINES;
    w_id_px      = pix_colour(w_px, w_ay, r_mode);
    w_id_pair    = pix_colour(w_px_even, w_ay, r_mode);
    w_y          = luma(w_id_px);
    w_cb         = chroma_b(w_id_pair);
    w_cr         = chroma_r(w_id_pair);
    w_href       = (r_state == S_ACTIVE) && (r_col < C_HREF_END);
    w_strobe     = w_href && r_col[0];
    w_col_last   = (r_col == C_COL_LAST);
    w_frame_last = (r_state == S_ACTIVE) && w_col_last && (r_line == C_LN_LAST);
    case (r_col[1:0])
      2'd0:    w_byte = w_cb;
      2'd2:    w_byte = w_cr;
      default: w_byte = w_y;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_col      <= '0;
      r_line     <= '0;
      r_mode     <= 2'd0;
      VSYNC      <= 1'b0;
      HREF       <= 1'b0;
      D          <= 8'h00;
      e_pix      <= 1'b0;
      Y          <= 8'h00;
      Cb         <= 8'h00;
      Cr         <= 8'h00;
      frame_done <= 1'b0;
    end else if (r_state == S_IDLE) begin
      VSYNC      <= 1'b0;
      HREF       <= 1'b0;
      D          <= 8'h00;
      e_pix      <= 1'b0;
      Y          <= 8'h00;
      Cb         <= 8'h00;
      Cr         <= 8'h00;
      frame_done <= 1'b0;
      if (enable) begin
        r_mode  <= mode;
        r_col   <= '0;
        r_line  <= '0;
        r_state <= S_VSYNC;
      end
    end else begin
      VSYNC      <= (r_state == S_VSYNC);
      HREF       <= w_href;
      D          <= w_href ? w_byte : 8'h00;
      e_pix      <= w_strobe;
      frame_done <= w_frame_last;
      if (w_strobe) begin
        Y  <= w_y;
        Cb <= w_cb;
        Cr <= w_cr;
      end
      if (!w_col_last) begin
        r_col <= r_col + 1'b1;
      end else begin
        r_col <= '0;
        case (r_state)
          S_VSYNC: begin
            r_line <= r_line + 1'b1;
            if (r_line == C_VS_LAST) r_state <= S_VBLANK;
          end
          S_VBLANK: begin
            r_line <= r_line + 1'b1;
            if (r_line == C_VB_LAST) r_state <= S_ACTIVE;
          end
          S_ACTIVE: begin
            if (r_line == C_LN_LAST) begin
              // Back-to-back frames restart at VSYNC line 0 with no idle gap
              r_line <= '0;
              if (enable) begin
                r_mode  <= mode;
                r_state <= S_VSYNC;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_line <= r_line + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ycbcr_stream_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ycbcr_stream_gen                                                      |
// | Self-checking bench for ycbcr_stream_gen with a frame-level model.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ycbcr_stream_gen;

  localparam int HA = 8, HB = 4, VA = 4, VB = 3, VS = 1;
  localparam int BX0 = 2, BY0 = 1, BW = 4, BH = 2;
  localparam int LL = 2 * HA + HB;
  localparam int FRAME = LL * (VB + VA);

  localparam logic [7:0] ROW_BOX  [16] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h36, 8'h91, 8'h22, 8'h91,
                                           8'h36, 8'h91, 8'h22, 8'h91, 8'h80, 8'h80, 8'h80, 8'h80};
  localparam logic [7:0] ROW_BARS [16] = '{8'h36, 8'h91, 8'h22, 8'h91, 8'h5A, 8'h51, 8'hF0, 8'h51,
                                           8'hF0, 8'h29, 8'h6E, 8'h29, 8'h80, 8'h80, 8'h80, 8'h80};

  logic       PCLK = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       VSYNC, HREF, e_pix, frame_done;
  logic [7:0] D, Y, Cb, Cr;

  int checks = 0;
  int errors = 0;
  logic [7:0] m_y = 8'h00, m_cb = 8'h00, m_cr = 8'h00;
  logic [7:0] cap [VA][2*HA];
  int n_href, n_epix, n_done, n_y91, n_ybytes;

  ycbcr_stream_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB), .VSYNC_LINES(VS),
    .BOX_X0(BX0), .BOX_Y0(BY0), .BOX_W(BW), .BOX_H(BH)
  ) dut (
    .PCLK(PCLK), .reset_n(reset_n), .enable(enable), .mode(mode),
    .VSYNC(VSYNC), .HREF(HREF), .D(D), .e_pix(e_pix),
    .Y(Y), .Cb(Cb), .Cr(Cr), .frame_done(frame_done)
  );

  always #5 PCLK = ~PCLK;

  // Colour as {Y,Cb,Cr} straight from the pattern rules
  function automatic logic [23:0] ref_colour(input int px, input int ay, input int m);
    if (m == 0) return (px >= BX0 && px < BX0 + BW && ay >= BY0 && ay < BY0 + BH) ? 24'h913622 : 24'h808080;
    if (m == 1) begin
      case (px / (HA / 4))
        0: return 24'h913622;
        1: return 24'h515AF0;
        2: return 24'h29F06E;
        default: return 24'h808080;
      endcase
    end
    if (m == 2) return 24'h808080;
    return 24'h913622;
  endfunction

  // Steps npos frame positions, comparing every cycle against the model
  task automatic run_frame(input int m, input logic [1:0] m_next, input logic en_next,
                           input bit scramble, input int npos);
    n_href = 0; n_epix = 0; n_done = 0; n_y91 = 0; n_ybytes = 0;
    for (int p = 0; p < npos; p++) begin
      int line, col, ay, px;
      logic [23:0] cy, cc;
      logic e_vs, e_hr, e_ep, e_fd;
      logic [7:0] e_d;
      line = p / LL;
      col  = p % LL;
      if (p == FRAME - 1) begin
        mode = m_next; enable = en_next;
      end else if (scramble) begin
        mode = 2'($urandom_range(0, 3)); enable = 1'($urandom_range(0, 1));
      end
      @(posedge PCLK); #1;
      e_vs = (line < VS);
      e_hr = (line >= VB) && (col < 2 * HA);
      e_d = 8'h00; e_ep = 1'b0; ay = line - VB;
      if (e_hr) begin
        px = col / 2;
        cy = ref_colour(px, ay, m);
        cc = ref_colour(px - (px % 2), ay, m);
        case (col % 4)
          0: e_d = cc[15:8];
          2: e_d = cc[7:0];
          default: e_d = cy[23:16];
        endcase
        e_ep = (col % 2 == 1);
        if (e_ep) begin m_y = cy[23:16]; m_cb = cc[15:8]; m_cr = cc[7:0]; end
        cap[ay][col] = D;
      end
      e_fd = (p == FRAME - 1);
      checks++;
      if ({VSYNC, HREF, e_pix, frame_done} !== {e_vs, e_hr, e_ep, e_fd}) begin
        errors++;
        $display("FAIL ctrl pos %0d: got vs/href/epix/done %b expected %b", p,
                 {VSYNC, HREF, e_pix, frame_done}, {e_vs, e_hr, e_ep, e_fd});
      end
      checks++;
      if (D !== e_d) begin
        errors++;
        $display("FAIL data pos %0d: got D %h expected %h", p, D, e_d);
      end
      checks++;
      if ({Y, Cb, Cr} !== {m_y, m_cb, m_cr}) begin
        errors++;
        $display("FAIL sideband pos %0d: got %h expected %h", p, {Y, Cb, Cr}, {m_y, m_cb, m_cr});
      end
      n_href += int'(HREF);
      n_epix += int'(e_pix);
      n_done += int'(frame_done);
      if (e_hr && (col % 2 == 1)) begin
        n_ybytes++;
        if (D == 8'h91) n_y91++;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; mode = 2'd0;
    m_y = 8'h00; m_cb = 8'h00; m_cr = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK); #1;
      checks++;
      if ({VSYNC, HREF, D, e_pix, Y, Cb, Cr, frame_done} !== 38'h0) begin
        errors++;
        $display("FAIL reset_outputs: got %h expected 0", {VSYNC, HREF, D, e_pix, Y, Cb, Cr, frame_done});
      end
    end
  endtask

  task automatic test_first_frame();
    reset_n = 1'b1; enable = 1'b1; mode = 2'd0;
    @(posedge PCLK); #1;
    checks++;
    if ({VSYNC, HREF, D, e_pix, frame_done} !== 12'h0) begin
      errors++;
      $display("FAIL start_edge: got %h expected 0", {VSYNC, HREF, D, e_pix, frame_done});
    end
    run_frame(0, 2'd1, 1'b1, 1'b0, FRAME);
    checks++;
    if (n_href !== 4 * 2 * HA) begin errors++; $display("FAIL href_count: got %0d expected %0d", n_href, 8 * HA); end
    checks++;
    if (n_epix !== 32) begin errors++; $display("FAIL epix_count: got %0d expected 32", n_epix); end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL done_count: got %0d expected 1", n_done); end
    for (int a = 0; a < VA; a++)
      for (int c = 0; c < 2 * HA; c++) begin
        logic [7:0] ex;
        ex = (a == 1 || a == 2) ? ROW_BOX[c] : 8'h80;
        checks++;
        if (cap[a][c] !== ex) begin
          errors++;
          $display("FAIL box_row ay %0d col %0d: got %h expected %h", a, c, cap[a][c], ex);
        end
      end
  endtask

  task automatic test_bars();
    run_frame(1, 2'd3, 1'b1, 1'b0, FRAME);
    for (int a = 0; a < VA; a++)
      for (int c = 0; c < 2 * HA; c++) begin
        checks++;
        if (cap[a][c] !== ROW_BARS[c]) begin
          errors++;
          $display("FAIL bar_row ay %0d col %0d: got %h expected %h", a, c, cap[a][c], ROW_BARS[c]);
        end
      end
  endtask

  task automatic test_mode_switch();
    run_frame(3, 2'd0, 1'b1, 1'b1, FRAME);
    // Frame with random mid-frame mode/enable noise still shows the box
    run_frame(0, 2'd3, 1'b1, 1'b1, FRAME);
    for (int c = 0; c < 2 * HA; c++) begin
      checks++;
      if (cap[1][c] !== ROW_BOX[c]) begin
        errors++;
        $display("FAIL switch_box col %0d: got %h expected %h", c, cap[1][c], ROW_BOX[c]);
      end
    end
  endtask

  task automatic test_enable_drop();
    run_frame(3, 2'd2, 1'b0, 1'b1, FRAME);
    checks++;
    if (n_y91 !== 32 || n_ybytes !== 32) begin
      errors++; $display("FAIL all_green: got %0d of %0d Y bytes 91 expected 32 of 32", n_y91, n_ybytes);
    end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL drop_done: got %0d expected 1", n_done); end
    m_y = 8'h00; m_cb = 8'h00; m_cr = 8'h00;
    for (int i = 0; i < 200; i++) begin
      mode = 2'($urandom_range(0, 3)); enable = 1'b0;
      @(posedge PCLK); #1;
      checks++;
      if ({VSYNC, HREF, D, e_pix, Y, Cb, Cr, frame_done} !== 38'h0) begin
        errors++;
        $display("FAIL idle cycle %0d: got %h expected 0", i, {VSYNC, HREF, D, e_pix, Y, Cb, Cr, frame_done});
      end
    end
    enable = 1'b1; mode = 2'd1;
    @(posedge PCLK); #1;
    checks++;
    if ({VSYNC, HREF, D, e_pix, frame_done} !== 12'h0) begin
      errors++; $display("FAIL reenable_edge: got %h expected 0", {VSYNC, HREF, D, e_pix, frame_done});
    end
    run_frame(1, 2'd0, 1'b1, 1'b0, FRAME);
  endtask

  task automatic test_reset_mid_line();
    run_frame(0, 2'd0, 1'b1, 1'b1, 70);
    reset_n = 1'b0; enable = 1'b1; mode = 2'd0;
    @(posedge PCLK); #1;
    m_y = 8'h00; m_cb = 8'h00; m_cr = 8'h00;
    checks++;
    if ({VSYNC, HREF, D, e_pix, Y, Cb, Cr, frame_done} !== 38'h0) begin
      errors++; $display("FAIL mid_reset: got %h expected 0", {VSYNC, HREF, D, e_pix, Y, Cb, Cr, frame_done});
    end
    reset_n = 1'b1;
    @(posedge PCLK); #1;
    checks++;
    if ({VSYNC, HREF, D, e_pix, frame_done} !== 12'h0) begin
      errors++; $display("FAIL restart_edge: got %h expected 0", {VSYNC, HREF, D, e_pix, frame_done});
    end
    run_frame(0, 2'd0, 1'b1, 1'b0, FRAME);
    checks++;
    if (n_epix !== 32 || n_done !== 1) begin
      errors++; $display("FAIL restart_counts: got epix %0d done %0d expected 32 1", n_epix, n_done);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_bars();
    test_mode_switch();
    test_enable_drop();
    test_reset_mid_line();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
